// File: rtl/aes256_pkg.sv
// aes256_pkg: shared AES-256 datapath widths and word/block FSM encoding
package aes256_pkg;
    localparam int WSIZE  = 32;
    localparam int BSIZE  = 128;
    localparam int NWORDS = BSIZE / WSIZE;
    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} wb_state_t;
endpackage

// File: rtl/block_to_word_disassembler.sv
// block_to_word_disassembler: splits 128-bit result blocks into 32-bit words, MS word first
//   clock/reset              : clock, async active-high reset
//   block_in/block_in_ready  : head and not-empty of the output block FIFO
//   pull_block               : pop strobe; block_in captured on the same edge
//   word_out/word_out_valid  : word and write enable to the output word FIFO
//   word_out_hold            : output word FIFO full
//   busy                     : a captured block still has unsent words
module block_to_word_disassembler
    import aes256_pkg::*;
#(
    parameter int WSIZE = aes256_pkg::WSIZE,
    parameter int BSIZE = aes256_pkg::BSIZE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [BSIZE-1:0] block_in,
    input  logic             block_in_ready,
    output logic             pull_block,
    output logic [WSIZE-1:0] word_out,
    output logic             word_out_valid,
    input  logic             word_out_hold,
    output logic             busy
);
    localparam int NW = BSIZE / WSIZE;
    localparam int CW = NW > 1 ? $clog2(NW) : 1;

    if (BSIZE % WSIZE != 0) begin : g_bad_size
        $error("BSIZE must be an integer multiple of WSIZE");
    end

    wb_state_t        state;
    logic [BSIZE-1:0] buffer;
    logic [CW-1:0]    count;
    logic             last;

    assign last           = count == CW'(NW - 1);
    assign busy           = state == EMIT;
    assign word_out       = buffer[BSIZE-1 -: WSIZE];
    assign word_out_valid = busy && !word_out_hold;
    // Refill either from IDLE or in the same cycle the last word leaves, so blocks stream without bubbles.
    assign pull_block     = !reset && block_in_ready && (busy ? last && !word_out_hold : 1'b1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            buffer <= '0;
            count  <= '0;
        end else if (pull_block) begin
            state  <= EMIT;
            buffer <= block_in;
            count  <= '0;
        end else if (word_out_valid) begin
            state  <= last ? IDLE : EMIT;
            buffer <= buffer << WSIZE;
            count  <= last ? '0 : count + CW'(1);
        end
    end
endmodule

// File: tb/tb_block_to_word_disassembler.sv
// tb_block_to_word_disassembler: random and directed checks against a word-queue reference model
module tb_block_to_word_disassembler;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] block_in = '0;
    logic         block_in_ready = 1'b0;
    logic         pull_block;
    logic [31:0]  word_out;
    logic         word_out_valid;
    logic         word_out_hold = 1'b0;
    logic         busy;

    always #5 clock = ~clock;

    block_to_word_disassembler dut (
        .clock(clock),
        .reset(reset),
        .block_in(block_in),
        .block_in_ready(block_in_ready),
        .pull_block(pull_block),
        .word_out(word_out),
        .word_out_valid(word_out_valid),
        .word_out_hold(word_out_hold),
        .busy(busy)
    );

    logic [127:0] src[$];
    logic [31:0]  q[$];
    logic [31:0]  exp_out[$];
    logic [31:0]  got[$];
    int n_checks = 0;
    int n_fail = 0;
    int pulls = 0;
    int run = 0;
    int maxrun = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic e_busy, e_valid, e_pull;
        logic [31:0] e_word;
        logic [127:0] b;
        block_in_ready = src.size() > 0;
        block_in = block_in_ready ? src[0] : {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        e_busy  = q.size() > 0;
        e_valid = e_busy && !word_out_hold;
        e_pull  = block_in_ready && (q.size() == 0 || (q.size() == 1 && !word_out_hold));
        e_word  = e_busy ? q[0] : 32'h0;
        chk("busy", 128'(busy), 128'(e_busy));
        chk("valid", 128'(word_out_valid), 128'(e_valid));
        chk("pull", 128'(pull_block), 128'(e_pull));
        chk("word", 128'(word_out), 128'(e_word));
        if (word_out_valid) got.push_back(word_out);
        if (pull_block) pulls++;
        run = word_out_valid ? run + 1 : 0;
        if (run > maxrun) maxrun = run;
        @(posedge clock);
        if (e_valid) void'(q.pop_front());
        if (e_pull) begin
            b = src.pop_front();
            for (int k = 0; k < 4; k++) begin
                q.push_back(b[127-32*k -: 32]);
                exp_out.push_back(b[127-32*k -: 32]);
            end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        src.push_back(128'h1);
        block_in_ready = 1'b1;
        block_in = '1;
        #2;
        chk("rst_pull", 128'(pull_block), 128'(0));
        chk("rst_valid", 128'(word_out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_word", 128'(word_out), 128'(0));
        src.delete();
        block_in_ready = 1'b0;
        #10 reset = 1'b0;
        @(posedge clock);
        #1;

        ticks(20);
        chk("empty_pulls", 128'(pulls), 128'(0));

        src.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
        pulls = 0;
        got.delete();
        exp_out.delete();
        ticks(7);
        chk("single_pulls", 128'(pulls), 128'(1));
        chk("single_n", 128'(got.size()), 128'(4));
        chk("single_w0", 128'(got[0]), 128'(32'h00112233));
        chk("single_w1", 128'(got[1]), 128'(32'h44556677));
        chk("single_w2", 128'(got[2]), 128'(32'h8899AABB));
        chk("single_w3", 128'(got[3]), 128'(32'hCCDDEEFF));

        src.push_back(128'hAAAA0000_AAAA0001_AAAA0002_AAAA0003);
        src.push_back(128'hBBBB0000_BBBB0001_BBBB0002_BBBB0003);
        pulls = 0;
        maxrun = 0;
        ticks(11);
        chk("b2b_pulls", 128'(pulls), 128'(2));
        chk("b2b_run", 128'(maxrun), 128'(8));

        src.push_back(128'h11110000_22220000_33330000_44440000);
        ticks(3);
        word_out_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_word3", 128'(word_out), 128'(32'h33330000));
        end
        word_out_hold = 1'b0;
        ticks(4);

        src.push_back(128'h55550000_55550001_55550002_55550003);
        src.push_back(128'h66660000_66660001_66660002_66660003);
        ticks(4);
        pulls = 0;
        word_out_hold = 1'b1;
        ticks(3);
        chk("last_stall_pulls", 128'(pulls), 128'(0));
        word_out_hold = 1'b0;
        ticks(6);
        chk("last_release_pulls", 128'(pulls), 128'(1));

        src.push_back(128'h77770000_77770001_77770002_77770003);
        ticks(3);
        src.push_back(128'h88880000_88880001_88880002_88880003);
        block_in_ready = 1'b1;
        block_in = src[0];
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(word_out_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_word", 128'(word_out), 128'(0));
        chk("mid_rst_pull", 128'(pull_block), 128'(0));
        for (int i = 0; i < q.size(); i++) void'(exp_out.pop_back());
        q.delete();
        src.delete();
        block_in_ready = 1'b0;
        @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;
        ticks(6);

        for (int i = 0; i < 400; i++) begin
            if (src.size() < 3 && $urandom_range(0, 2) != 0)
                src.push_back({$urandom, $urandom, $urandom, $urandom});
            word_out_hold = $urandom_range(0, 3) == 0;
            tick();
        end
        word_out_hold = 1'b0;
        ticks(20);

        chk("sb_count", 128'(got.size()), 128'(exp_out.size()));
        for (int i = 0; i < got.size() && i < exp_out.size(); i++)
            chk("sb_word", 128'(got[i]), 128'(exp_out[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
